// File: rtl/ftsd_result_sequencer.sv
// ftsd_result_sequencer: FTSD digit content for live scores and a scrolling WIN/LOSE/TIE verdict
// Ports: clk; rst_n (async, active-low); tick (paces scroll and blink);
//   sys_status (110 scores, 111 result, otherwise blank);
//   score_self_bcd / score_send_bcd (BCD scores, MSD at MSBs) shown in score mode;
//   score_self / score_send (binary scores) compared for the verdict;
//   disp (6-bit font code per digit, digit 0 leftmost at the MSBs);
//   scroll_done (one-cycle pulse with the first left-aligned frame).
// Define FTSD_BLINK_EN to blink the held verdict every BLINK_TICKS ticks.
`ifndef FONT_BLANK
`define FONT_BLANK 6'd63
`endif
`ifndef FONT_E
`define FONT_E 6'd16
`endif
`ifndef FONT_I
`define FONT_I 6'd17
`endif
`ifndef FONT_L
`define FONT_L 6'd18
`endif
`ifndef FONT_N
`define FONT_N 6'd19
`endif
`ifndef FONT_O
`define FONT_O 6'd20
`endif
`ifndef FONT_S
`define FONT_S 6'd21
`endif
`ifndef FONT_T
`define FONT_T 6'd22
`endif
`ifndef FONT_W
`define FONT_W 6'd23
`endif

module ftsd_result_sequencer #(
  parameter int DIGITS = 4,
  parameter int SCORE_DIGITS = 2,
  parameter int SCORE_W = 8,
  parameter int BLINK_TICKS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [2:0]                sys_status,
  input  logic [4*SCORE_DIGITS-1:0] score_self_bcd,
  input  logic [4*SCORE_DIGITS-1:0] score_send_bcd,
  input  logic [SCORE_W-1:0]        score_self,
  input  logic [SCORE_W-1:0]        score_send,
  output logic [6*DIGITS-1:0]       disp,
  output logic                      scroll_done
);
  localparam int PW = $clog2(DIGITS + 1);
  typedef enum logic [1:0] {IDLE, SCORE, SCROLL, HOLD} state_t;
  typedef enum logic [1:0] {V_WIN, V_LOSE, V_TIE} verdict_t;
  state_t state, state_nxt;
  verdict_t verdict, verdict_nxt;
  logic [PW-1:0] p, p_nxt;
  logic to_scroll, blank_nxt;
  logic [6*DIGITS-1:0] disp_nxt;
  // Character k of the verdict message; anything outside the message is blank.
  function automatic logic [5:0] msg_font(input verdict_t v, input int k);
    return (k < 0 || k >= (v == V_LOSE ? 4 : 3)) ? `FONT_BLANK :
           v == V_WIN ? (k == 0 ? `FONT_W : k == 1 ? `FONT_I : `FONT_N) :
           v == V_TIE ? (k == 0 ? `FONT_T : k == 1 ? `FONT_I : `FONT_E) :
           (k == 0 ? `FONT_L : k == 1 ? `FONT_O : k == 2 ? `FONT_S : `FONT_E);
  endfunction
  always_comb begin
    to_scroll = sys_status == 3'b111 && (state == IDLE || state == SCORE);
    state_nxt = sys_status == 3'b110 ? SCORE :
                sys_status != 3'b111 ? IDLE :
                to_scroll ? SCROLL :
                (state == SCROLL && tick && p == PW'(DIGITS - 1)) ? HOLD : state;
    // Entry into SCROLL clears p, so a tick on the entry cycle never advances it.
    p_nxt = state_nxt == HOLD ? PW'(DIGITS) :
            (state_nxt == SCROLL && !to_scroll) ? p + PW'(tick) : '0;
    verdict_nxt = !to_scroll ? verdict :
                  score_self > score_send ? V_WIN :
                  score_self < score_send ? V_LOSE : V_TIE;
  end
`ifdef FTSD_BLINK_EN
  logic [3:0] blink_cnt, blink_cnt_nxt;
  logic blank, hold_stay;
  always_comb begin
    hold_stay = state == HOLD && state_nxt == HOLD;
    blink_cnt_nxt = !hold_stay ? 4'd0 : !tick ? blink_cnt :
                    blink_cnt == 4'(BLINK_TICKS - 1) ? 4'd0 : blink_cnt + 4'd1;
    blank_nxt = hold_stay && (blank ^ (tick && blink_cnt == 4'(BLINK_TICKS - 1)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blank <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blank <= blank_nxt;
    end
  end
`else
  assign blank_nxt = 1'b0;
`endif
  // The frame is built from next-state values so disp lines up with the state it reflects.
  always_comb begin
    disp_nxt = {DIGITS{`FONT_BLANK}};
    if (state_nxt == SCORE) begin
      for (int j = 0; j < SCORE_DIGITS; j++) begin
        disp_nxt[6*(DIGITS-1-j) +: 6] = {2'b00, score_self_bcd[4*(SCORE_DIGITS-1-j) +: 4]};
        disp_nxt[6*(SCORE_DIGITS-1-j) +: 6] = {2'b00, score_send_bcd[4*(SCORE_DIGITS-1-j) +: 4]};
      end
    end else if ((state_nxt == SCROLL || state_nxt == HOLD) && !blank_nxt) begin
      for (int i = 0; i < DIGITS; i++)
        disp_nxt[6*(DIGITS-1-i) +: 6] = msg_font(verdict_nxt, i - DIGITS + int'(p_nxt));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      verdict <= V_LOSE;
      p <= '0;
      disp <= {DIGITS{`FONT_BLANK}};
      scroll_done <= 1'b0;
    end else begin
      state <= state_nxt;
      verdict <= verdict_nxt;
      p <= p_nxt;
      disp <= disp_nxt;
      scroll_done <= state == SCROLL && state_nxt == HOLD;
    end
  end
endmodule

// File: tb/tb_ftsd_result_sequencer.sv
// tb_ftsd_result_sequencer: directed checks of score layout, verdict scroll, hold, abort and reset
`ifndef FONT_BLANK
`define FONT_BLANK 6'd63
`endif
`ifndef FONT_E
`define FONT_E 6'd16
`endif
`ifndef FONT_I
`define FONT_I 6'd17
`endif
`ifndef FONT_L
`define FONT_L 6'd18
`endif
`ifndef FONT_N
`define FONT_N 6'd19
`endif
`ifndef FONT_O
`define FONT_O 6'd20
`endif
`ifndef FONT_S
`define FONT_S 6'd21
`endif
`ifndef FONT_T
`define FONT_T 6'd22
`endif
`ifndef FONT_W
`define FONT_W 6'd23
`endif

module tb_ftsd_result_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [2:0] sys_status = 3'b000;
  logic [7:0] sb = '0, nb = '0, ss = '0, ns = '0;
  logic [23:0] disp;
  logic [35:0] disp6;
  logic done, done6;
  int checks = 0, errors = 0;
  localparam logic [5:0] B = `FONT_BLANK, W = `FONT_W, I = `FONT_I, N = `FONT_N;
  localparam logic [5:0] L = `FONT_L, O = `FONT_O, S = `FONT_S, E = `FONT_E, T = `FONT_T;
  ftsd_result_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sys_status(sys_status),
    .score_self_bcd(sb), .score_send_bcd(nb), .score_self(ss), .score_send(ns),
    .disp(disp), .scroll_done(done)
  );
  ftsd_result_sequencer #(.DIGITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sys_status(sys_status),
    .score_self_bcd(sb), .score_send_bcd(nb), .score_self(ss), .score_send(ns),
    .disp(disp6), .scroll_done(done6)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_disp", disp, {B, B, B, B});
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    sys_status = 3'b110; sb = 8'h37; nb = 8'h05;
    step();
    chk("score_3705", disp, {6'd3, 6'd7, 6'd0, 6'd5});
    sb = 8'h12; nb = 8'h99; tick = 1'b1;
    step();
    tick = 1'b0;
    chk("score_1299", disp, {6'd1, 6'd2, 6'd9, 6'd9});
    chk("score6_1299", disp6, {6'd1, 6'd2, B, B, 6'd9, 6'd9});
    ss = 20; ns = 10; sys_status = 3'b111; tick = 1'b1;
    step();
    tick = 1'b0;
    chk("win_f0", disp, {B, B, B, B});
    pulse;
    chk("win_f1", disp, {B, B, B, W});
    chk("win_done_early", done, 0);
    pulse;
    chk("win_f2", disp, {B, B, W, I});
    pulse;
    chk("win_f3", disp, {B, W, I, N});
    pulse;
    chk("win_f4", disp, {W, I, N, B});
    chk("win_done", done, 1);
    step();
    chk("win_done_off", done, 0);
    ss = 0;
    step();
    chk("win_latched", disp, {W, I, N, B});
    for (int t = 1; t <= 10; t++) begin
      pulse;
      step();
`ifdef FTSD_BLINK_EN
      chk("blink", disp, ((t / 2) % 2 == 1) ? {B, B, B, B} : {W, I, N, B});
`else
      chk("steady", disp, {W, I, N, B});
`endif
    end
    sys_status = 3'b110; ss = 3; ns = 9;
    step();
    chk("hold_to_score", disp, {6'd1, 6'd2, 6'd9, 6'd9});
    sys_status = 3'b111;
    step();
    pulse;
    chk("lose_f1", disp, {B, B, B, L});
    repeat (3) pulse;
    chk("lose_f4", disp, {L, O, S, E});
    chk("lose_done", done, 1);
    sys_status = 3'b110; ss = 7; ns = 7; sb = 8'h07; nb = 8'h07;
    step();
    sys_status = 3'b111;
    step();
    repeat (4) pulse;
    chk("tie_f4", disp, {T, I, E, B});
    sys_status = 3'b110;
    step();
    sys_status = 3'b111;
    step();
    pulse;
    chk("abort_f1", disp, {B, B, B, T});
    sys_status = 3'b110; tick = 1'b1;
    step();
    tick = 1'b0;
    chk("abort_score", disp, {6'd0, 6'd7, 6'd0, 6'd7});
    for (int c = 0; c < 4; c++) begin
      chk("abort_no_done", done, 0);
      step();
    end
    sys_status = 3'b111;
    step();
    pulse;
    pulse;
    chk("rs_f2", disp, {B, B, T, I});
    sys_status = 3'b101; ss = 20; ns = 10;
    step();
    chk("rs_idle", disp, {B, B, B, B});
    sys_status = 3'b111;
    step();
    chk("rs_f0", disp, {B, B, B, B});
    pulse;
    chk("rs_f1", disp, {B, B, B, W});
    pulse;
    rst_n = 1'b0;
    #2;
    chk("rst_mid_disp", disp, {B, B, B, B});
    chk("rst_mid_done", done, 0);
    step();
    rst_n = 1'b1; sys_status = 3'b110; sb = 8'h37; nb = 8'h05;
    step();
    chk("rst_score", disp, {6'd3, 6'd7, 6'd0, 6'd5});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
